// File: rtl/goertzel_pkg.sv
// goertzel_pkg: state encoding and wide arithmetic helpers shared by the Goertzel filter bank.
package goertzel_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN
    } state_t;

    // Coefficients are Q2.(CW-2); modules derive their fraction-bit count as CW - COEF_INT_BITS.
    localparam int COEF_INT_BITS = 2;

    localparam int HW = 128;
    typedef logic signed [HW-1:0] wide_t;

    // Arithmetic right shift of a signed value; rounds toward minus infinity.
    function automatic wide_t asr_trunc(input wide_t v, input int sh);
        return v >>> sh;
    endfunction

    // Clamp to the w-bit signed range, or to [0, 2^w-1] when is_unsigned is set.
    function automatic wide_t sat_clamp(input wide_t v, input int w, input logic is_unsigned);
        wide_t hi;
        wide_t lo;
        if (is_unsigned) begin
            hi = (wide_t'(1) <<< w) - wide_t'(1);
            lo = '0;
        end else begin
            hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
            lo = -(wide_t'(1) <<< (w - 1));
        end
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/goertzel_mac.sv
// goertzel_mac: combinational single-channel Goertzel state update s = x + coef*s1 - s2.
// With GOERTZEL_OVF_EN defined the result saturates to SW bits and ovf_bit flags it.
module goertzel_mac
    import goertzel_pkg::*;
#(
    parameter int DW = 8,
    parameter int CW = 18,
    parameter int SW = 32
) (
    input  logic signed [DW-1:0] x,
    input  logic signed [CW-1:0] coef,
    input  logic signed [SW-1:0] s1,
    input  logic signed [SW-1:0] s2,
    output logic signed [SW-1:0] s
`ifdef GOERTZEL_OVF_EN
    ,
    output logic                 ovf_bit
`endif
);

    localparam int FRAC = CW - COEF_INT_BITS;

    logic signed [CW+SW-1:0] prod;
`ifdef GOERTZEL_OVF_EN
    wide_t full;
    wide_t clamp;
`endif

    always_comb begin
        prod = (CW+SW)'(coef) * (CW+SW)'(s1);
`ifdef GOERTZEL_OVF_EN
        full    = wide_t'(x) + asr_trunc(wide_t'(prod), FRAC) - wide_t'(s2);
        clamp   = sat_clamp(full, SW, 1'b0);
        s       = SW'(clamp);
        ovf_bit = (clamp != full);
`else
        s = SW'(x) + SW'(asr_trunc(wide_t'(prod), FRAC)) - s2;
`endif
    end

endmodule

// File: rtl/goertzel_bank.sv
// goertzel_bank: time-multiplexed Goertzel bank; one shared MAC updates NCH channels per sample,
// then streams per-channel power. GOERTZEL_OVF_EN enables state saturation and a sticky ovf flag.
module goertzel_bank
    import goertzel_pkg::*;
#(
    parameter int NCH = 12,
    parameter int DW  = 8,
    parameter int CW  = 18,
    parameter int SW  = 32,
    parameter int NW  = 16,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 coef_wr,
    input  logic [CHW-1:0]       coef_addr,
    input  logic signed [CW-1:0] coef_data,
    input  logic [NW-1:0]        num_samp,
    input  logic                 start,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    input  logic signed [DW-1:0] sample,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [CHW-1:0]       res_ch,
    output logic [2*SW-1:0]      res_power,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf
);

    localparam int FRAC = CW - COEF_INT_BITS;
    localparam int PW   = 2 * SW + 2;
    localparam logic [CHW-1:0] LAST_CH = CHW'(NCH - 1);

    state_t state;

    logic signed [CW-1:0] coef_mem [NCH];
    logic signed [SW-1:0] s1_mem   [NCH];
    logic signed [SW-1:0] s2_mem   [NCH];

    logic [CHW-1:0]       ch_idx;
    logic                 seq_active;
    logic signed [DW-1:0] x_reg;
    logic [NW-1:0]        num_lat;
    logic [NW-1:0]        samp_cnt;
    logic signed [SW-1:0] mac_s;

    logic signed [CW+SW-1:0] pw_prod;
    logic signed [PW-1:0]    pw_t;
    logic signed [PW-1:0]    pw_p;
    logic [2*SW-1:0]         pw_clip;

`ifdef GOERTZEL_OVF_EN
    logic mac_ovf;
    logic ovf_r;
    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif

    goertzel_mac #(
        .DW (DW),
        .CW (CW),
        .SW (SW)
    ) u_mac (
        .x    (x_reg),
        .coef (coef_mem[ch_idx]),
        .s1   (s1_mem[ch_idx]),
        .s2   (s2_mem[ch_idx]),
        .s    (mac_s)
`ifdef GOERTZEL_OVF_EN
        ,
        .ovf_bit (mac_ovf)
`endif
    );

    // Power of the channel under ch_idx, evaluated wide enough that it never wraps before clipping.
    always_comb begin
        pw_prod = (CW+SW)'(coef_mem[ch_idx]) * (CW+SW)'(s1_mem[ch_idx]);
        pw_t    = PW'(asr_trunc(wide_t'(pw_prod), FRAC));
        pw_p    = PW'(s1_mem[ch_idx]) * PW'(s1_mem[ch_idx])
                + PW'(s2_mem[ch_idx]) * PW'(s2_mem[ch_idx])
                - pw_t * PW'(s2_mem[ch_idx]);
        pw_clip = (2*SW)'(sat_clamp(wide_t'(pw_p), 2 * SW, 1'b1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ch_idx       <= '0;
            seq_active   <= 1'b0;
            x_reg        <= '0;
            num_lat      <= '0;
            samp_cnt     <= '0;
            sample_ready <= 1'b0;
            res_valid    <= 1'b0;
            res_ch       <= '0;
            res_power    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
`ifdef GOERTZEL_OVF_EN
            ovf_r        <= 1'b0;
`endif
            for (int k = 0; k < NCH; k++) begin
                coef_mem[k] <= '0;
                s1_mem[k]   <= '0;
                s2_mem[k]   <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (coef_wr && (int'(coef_addr) < NCH)) begin
                        coef_mem[coef_addr] <= coef_data;
                    end
                    if (start) begin
                        for (int k = 0; k < NCH; k++) begin
                            s1_mem[k] <= '0;
                            s2_mem[k] <= '0;
                        end
                        num_lat    <= num_samp;
                        samp_cnt   <= '0;
                        ch_idx     <= '0;
                        seq_active <= 1'b0;
                        busy       <= 1'b1;
`ifdef GOERTZEL_OVF_EN
                        ovf_r      <= 1'b0;
`endif
                        if (num_samp == '0) begin
                            state <= DRAIN;
                        end else begin
                            state        <= ACCUM;
                            sample_ready <= 1'b1;
                        end
                    end
                end
                // One accepted sample, then one channel update per cycle before the next is taken.
                ACCUM: begin
                    if (seq_active) begin
                        s1_mem[ch_idx] <= mac_s;
                        s2_mem[ch_idx] <= s1_mem[ch_idx];
`ifdef GOERTZEL_OVF_EN
                        if (mac_ovf) ovf_r <= 1'b1;
`endif
                        if (ch_idx == LAST_CH) begin
                            seq_active <= 1'b0;
                            ch_idx     <= '0;
                            if (samp_cnt == num_lat) begin
                                state <= DRAIN;
                            end else begin
                                sample_ready <= 1'b1;
                            end
                        end else begin
                            ch_idx <= ch_idx + 1'b1;
                        end
                    end else if (sample_valid && sample_ready) begin
                        x_reg        <= sample;
                        samp_cnt     <= samp_cnt + 1'b1;
                        sample_ready <= 1'b0;
                        seq_active   <= 1'b1;
                    end
                end
                // res_valid low means the current channel's power is being loaded this cycle.
                DRAIN: begin
                    if (!res_valid) begin
                        res_valid <= 1'b1;
                        res_ch    <= ch_idx;
                        res_power <= pw_clip;
                    end else if (res_ready) begin
                        res_valid <= 1'b0;
                        if (ch_idx == LAST_CH) begin
                            ch_idx <= '0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            ch_idx <= ch_idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_goertzel_bank.sv
// tb_goertzel_bank: scoreboard bench for goertzel_bank (SW=32 main instance plus an SW=12
// instance sharing its inputs); expectations come from a bench-side Goertzel model.
module tb_goertzel_bank;

    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int CW  = 18;
    localparam int SW  = 32;
    localparam int NW  = 16;
    localparam int SSW = 12;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 coef_wr;
    logic [1:0]           coef_addr;
    logic signed [CW-1:0] coef_data;
    logic [NW-1:0]        num_samp;
    logic                 start;
    logic                 sample_valid;
    logic signed [DW-1:0] sample;
    logic                 res_ready;

    logic                 sample_ready, res_valid, busy, done, ovf;
    logic [1:0]           res_ch;
    logic [2*SW-1:0]      res_power;

    logic                 sm_sample_ready, sm_res_valid, sm_busy, sm_done, sm_ovf;
    logic [1:0]           sm_res_ch;
    logic [2*SSW-1:0]     sm_res_power;

    int errors = 0;
    int checks = 0;

    int mcoef [NCH];
    int stim [$];

    typedef struct {
        int          ch;
        logic [63:0] power;
    } exp_t;
    exp_t exp_main [$];
    exp_t exp_small [$];

    always #5 clk = ~clk;

    goertzel_bank #(.NCH(NCH), .DW(DW), .CW(CW), .SW(SW), .NW(NW)) dut (
        .clk(clk), .rst(rst), .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
        .num_samp(num_samp), .start(start), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .sample(sample), .res_valid(res_valid),
        .res_ready(res_ready), .res_ch(res_ch), .res_power(res_power), .busy(busy),
        .done(done), .ovf(ovf)
    );

    goertzel_bank #(.NCH(NCH), .DW(DW), .CW(CW), .SW(SSW), .NW(NW)) dut_small (
        .clk(clk), .rst(rst), .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
        .num_samp(num_samp), .start(start), .sample_valid(sample_valid),
        .sample_ready(sm_sample_ready), .sample(sample), .res_valid(sm_res_valid),
        .res_ready(res_ready), .res_ch(sm_res_ch), .res_power(sm_res_power), .busy(sm_busy),
        .done(sm_done), .ovf(sm_ovf)
    );

    function automatic logic signed [127:0] model_fix(input logic signed [127:0] v, input int sw);
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        hi = (128'sd1 <<< (sw - 1)) - 128'sd1;
        lo = -(128'sd1 <<< (sw - 1));
`ifdef GOERTZEL_OVF_EN
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
`else
        if (hi < lo) return v;
        return (v <<< (128 - sw)) >>> (128 - sw);
`endif
    endfunction

    function automatic logic [63:0] model_power(input int k, input int sw);
        logic signed [127:0] s1, s2, s, c, t, p, pmax;
        s1 = 0;
        s2 = 0;
        c  = mcoef[k];
        foreach (stim[i]) begin
            s  = stim[i] + ((c * s1) >>> 16) - s2;
            s  = model_fix(s, sw);
            s2 = s1;
            s1 = s;
        end
        t    = (c * s1) >>> 16;
        p    = s1 * s1 + s2 * s2 - t * s2;
        pmax = (128'sd1 <<< (2 * sw)) - 128'sd1;
        if (p < 0) p = 0;
        else if (p > pmax) p = pmax;
        return p[63:0];
    endfunction

    task automatic push_expected(input bit with_small);
        for (int k = 0; k < NCH; k++) begin
            exp_main.push_back('{k, model_power(k, SW)});
            if (with_small) exp_small.push_back('{k, model_power(k, SSW)});
        end
    endtask

    task automatic write_coef(input int k, input int c);
        coef_wr   = 1'b1;
        coef_addr = 2'(k);
        coef_data = 18'(c);
        @(negedge clk);
        coef_wr   = 1'b0;
        mcoef[k]  = c;
    endtask

    task automatic start_frame(input int n);
        start    = 1'b1;
        num_samp = 16'(n);
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic send_sample(input int x, output bit ok);
        ok           = 1'b0;
        sample_valid = 1'b1;
        sample       = 8'(x);
        for (int i = 0; i < 40 && !ok; i++) begin
            if (sample_ready) ok = 1'b1;
            @(negedge clk);
        end
        sample_valid = 1'b0;
    endtask

    task automatic send_all(input string name);
        bit ok;
        foreach (stim[i]) begin
            send_sample(stim[i], ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL %s_accept%0d: sample_ready never seen, required a handshake", name, i);
            end
        end
    endtask

    task automatic wait_result(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (res_valid) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; coef_wr = 1'b0; coef_addr = '0; coef_data = '0; num_samp = '0;
        start = 1'b0; sample_valid = 1'b0; sample = '0; res_ready = 1'b0;
        for (int k = 0; k < NCH; k++) mcoef[k] = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, sample_ready, res_valid, done, ovf} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got busy/rdy/vld/done/ovf=%b, required 00000",
                     {busy, sample_ready, res_valid, done, ovf});
        end
        checks++;
        if (res_ch !== 2'd0 || res_power !== 64'd0) begin
            errors++;
            $display("[TB] FAIL reset_result: got ch=%0d power=%0d, required 0/0", res_ch, res_power);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || sample_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle: got busy=%b ready=%b, required 0/0", busy, sample_ready);
        end
    endtask

    task automatic test_fs4();
        bit ok;
        exp_t e;
        write_coef(0, 65536);
        write_coef(1, 0);
        write_coef(2, -131072);
        write_coef(3, 46341);
        stim = {100, 0, -100, 0, 100, 0, -100, 0};
        push_expected(1'b0);
        start_frame(8);
        send_all("fs4");
        for (int k = 0; k < NCH; k++) begin
            wait_result(ok);
            e = exp_main.pop_front();
            checks++;
            if (!ok || res_ch !== 2'(e.ch) || res_power !== e.power) begin
                errors++;
                $display("[TB] FAIL fs4_res%0d: got ch=%0d power=%0d, required ch=%0d power=%0d",
                         k, res_ch, res_power, e.ch, e.power);
            end
            if (k == 1) begin
                checks++;
                if (res_power !== 64'd160000) begin
                    errors++;
                    $display("[TB] FAIL fs4_ch1_power: got %0d, required 160000", res_power);
                end
            end
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fs4_done: got done=%b busy=%b, required 1/0", done, busy);
        end
    endtask

    task automatic test_fs2();
        bit ok;
        exp_t e;
        stim = {100, -100, 100, -100};
        push_expected(1'b0);
        start_frame(4);
        send_all("fs2");
        for (int k = 0; k < NCH; k++) begin
            wait_result(ok);
            e = exp_main.pop_front();
            checks++;
            if (!ok || res_ch !== 2'(e.ch) || res_power !== e.power) begin
                errors++;
                $display("[TB] FAIL fs2_res%0d: got ch=%0d power=%0d, required ch=%0d power=%0d",
                         k, res_ch, res_power, e.ch, e.power);
            end
            if (k == 2) begin
                checks++;
                if (res_power !== 64'd160000) begin
                    errors++;
                    $display("[TB] FAIL fs2_ch2_power: got %0d, required 160000", res_power);
                end
            end
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit unstable;
        int done_cnt;
        exp_t e;
        logic [1:0]  ch0;
        logic [63:0] pw0;
        stim = {5, -3, 12, -7, 1};
        push_expected(1'b0);
        start_frame(5);
        send_all("bp");
        for (int k = 0; k < NCH; k++) begin
            wait_result(ok);
            e   = exp_main.pop_front();
            ch0 = res_ch;
            pw0 = res_power;
            checks++;
            if (!ok || res_ch !== 2'(e.ch) || res_power !== e.power) begin
                errors++;
                $display("[TB] FAIL bp_res%0d: got ch=%0d power=%0d, required ch=%0d power=%0d",
                         k, res_ch, res_power, e.ch, e.power);
            end
            unstable = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (res_valid !== 1'b1 || res_ch !== ch0 || res_power !== pw0) unstable = 1'b1;
            end
            checks++;
            if (unstable) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d: result changed while stalled, required stable ch=%0d power=%0d",
                         k, ch0, pw0);
            end
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
        end
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        checks++;
        if (done_cnt != 1 || res_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_done: got %0d done pulses valid=%b, required 1 pulse valid=0",
                     done_cnt, res_valid);
        end
    endtask

    task automatic test_zero_samples();
        bit ok;
        bit ready_seen;
        exp_t e;
        stim = {};
        push_expected(1'b0);
        start_frame(0);
        sample_valid = 1'b1;
        sample       = 8'sd55;
        ready_seen   = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            wait_result(ok);
            if (sample_ready) ready_seen = 1'b1;
            e = exp_main.pop_front();
            checks++;
            if (!ok || res_ch !== 2'(e.ch) || res_power !== 64'd0 || e.power !== 64'd0) begin
                errors++;
                $display("[TB] FAIL zero_res%0d: got ch=%0d power=%0d, required ch=%0d power=0",
                         k, res_ch, res_power, e.ch);
            end
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
        end
        sample_valid = 1'b0;
        checks++;
        if (ready_seen || done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL zero_proto: got ready_seen=%b done=%b, required 0/1", ready_seen, done);
        end
    endtask

    task automatic test_ignored_ctrl();
        bit ok;
        exp_t e;
        stim = {20, -40, 60, -80, 33};
        push_expected(1'b0);
        start_frame(5);
        send_sample(stim[0], ok);
        start     = 1'b1;
        num_samp  = 16'd1;
        coef_wr   = 1'b1;
        coef_addr = 2'd1;
        coef_data = 18'sd12345;
        @(negedge clk);
        start   = 1'b0;
        coef_wr = 1'b0;
        checks++;
        if (!ok || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ign_busy: got accepted=%b busy=%b, required 1/1", ok, busy);
        end
        for (int i = 1; i < 5; i++) begin
            send_sample(stim[i], ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL ign_accept%0d: sample_ready never seen, required a handshake", i);
            end
        end
        for (int k = 0; k < NCH; k++) begin
            wait_result(ok);
            e = exp_main.pop_front();
            checks++;
            if (!ok || res_ch !== 2'(e.ch) || res_power !== e.power) begin
                errors++;
                $display("[TB] FAIL ign_res%0d: got ch=%0d power=%0d, required ch=%0d power=%0d",
                         k, res_ch, res_power, e.ch, e.power);
            end
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
        end
    endtask

    task automatic test_throughput();
        bit ok;
        int ready_cnt;
        int misplaced;
        exp_t e;
        stim = {7, 7, 7, 7, 7, 7, 7, 7};
        push_expected(1'b0);
        start_frame(8);
        sample_valid = 1'b1;
        sample       = 8'sd7;
        ready_cnt    = 0;
        misplaced    = 0;
        for (int i = 0; i < 40; i++) begin
            if (sample_ready) begin
                ready_cnt++;
                if (i % 5 != 0) misplaced++;
            end
            @(negedge clk);
        end
        sample_valid = 1'b0;
        checks++;
        if (ready_cnt != 8 || misplaced != 0) begin
            errors++;
            $display("[TB] FAIL tput_ready: got %0d ready cycles (%0d off-slot) in 40, required 8 (0)",
                     ready_cnt, misplaced);
        end
        for (int k = 0; k < NCH; k++) begin
            wait_result(ok);
            e = exp_main.pop_front();
            checks++;
            if (!ok || res_ch !== 2'(e.ch) || res_power !== e.power) begin
                errors++;
                $display("[TB] FAIL tput_res%0d: got ch=%0d power=%0d, required ch=%0d power=%0d",
                         k, res_ch, res_power, e.ch, e.power);
            end
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int done_cnt;
        exp_t e;
        stim = {100, 0, -100, 0, 100, 0, -100, 0};
        start_frame(8);
        for (int i = 0; i < 3; i++) send_sample(stim[i], ok);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, sample_ready, res_valid, done, ovf} !== 5'b0 || res_power !== 64'd0 || res_ch !== 2'd0) begin
            errors++;
            $display("[TB] FAIL rstmid_outputs: got busy/rdy/vld/done/ovf=%b power=%0d, required all 0",
                     {busy, sample_ready, res_valid, done, ovf}, res_power);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NCH; k++) mcoef[k] = 0;
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (done || busy) done_cnt++;
            @(negedge clk);
        end
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("[TB] FAIL rstmid_idle: got %0d cycles with done/busy, required 0", done_cnt);
        end
        write_coef(1, 0);
        push_expected(1'b0);
        start_frame(8);
        send_all("rstmid");
        for (int k = 0; k < NCH; k++) begin
            wait_result(ok);
            e = exp_main.pop_front();
            checks++;
            if (!ok || res_ch !== 2'(e.ch) || res_power !== e.power || (k == 1 && res_power !== 64'd160000)) begin
                errors++;
                $display("[TB] FAIL rstmid_res%0d: got ch=%0d power=%0d, required ch=%0d power=%0d",
                         k, res_ch, res_power, e.ch, e.power);
            end
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
        end
    endtask

    task automatic test_ovf();
        bit ok;
        exp_t e;
        exp_t es;
        logic exp_ovf;
`ifdef GOERTZEL_OVF_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        write_coef(0, -131072);
        stim = {};
        for (int i = 0; i < 64; i++) stim.push_back((i % 2 == 0) ? 127 : -127);
        push_expected(1'b1);
        start_frame(64);
        send_all("ovf");
        for (int k = 0; k < NCH; k++) begin
            wait_result(ok);
            e  = exp_main.pop_front();
            es = exp_small.pop_front();
            checks++;
            if (!ok || res_ch !== 2'(e.ch) || res_power !== e.power) begin
                errors++;
                $display("[TB] FAIL ovf_main_res%0d: got ch=%0d power=%0d, required ch=%0d power=%0d",
                         k, res_ch, res_power, e.ch, e.power);
            end
            checks++;
            if (sm_res_valid !== 1'b1 || sm_res_ch !== 2'(es.ch) || sm_res_power !== es.power[23:0]) begin
                errors++;
                $display("[TB] FAIL ovf_small_res%0d: got vld=%b ch=%0d power=%0d, required 1 ch=%0d power=%0d",
                         k, sm_res_valid, sm_res_ch, sm_res_power, es.ch, es.power);
            end
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
        end
        checks++;
        if (sm_ovf !== exp_ovf || ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_flag: got small=%b main=%b, required small=%b main=0", sm_ovf, ovf, exp_ovf);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_fs4();
        test_fs2();
        test_backpressure();
        test_zero_samples();
        test_ignored_ctrl();
        test_throughput();
        test_reset_midframe();
        test_ovf();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
